rgb_sequence_ctrl: RTL and testbench
====================================

// Module: rgb_sequence_ctrl
// PURPOSE
//   Programmable sequencer for the board RGB LED. It replaces a fixed colour cycle with a
//   table of up to NUM_STEPS {colour, duration} entries. The table is loaded over a
//   valid/ready port and then played once or looped on start/stop commands.
//   It sits between the control logic and the LED pins and owns the registered red/green/blue drive.
// PARAMETERS
//   NUM_STEPS  8      table depth (power of 2, >=2); IW = $clog2(NUM_STEPS)
//   TICK_DIV   12000  clk cycles per duration tick (12 MHz -> 1 ms)
//   DUR_W      10     width of per-step duration, in ticks
// PORTS
//   clk        in   1      system clock
//   rst        in   1      synchronous reset, active-high
//   cfg_valid  in   1      table write request
//   cfg_ready  out  1      table write accept; 1 only in IDLE
//   cfg_idx    in   IW     table entry to write
//   cfg_color  in   3      {r,g,b} colour for the entry
//   cfg_dur    in   DUR_W  entry duration in ticks; 0 is treated as 1
//   cfg_last   in   IW     index of last step played; sampled on start
//   loop_en    in   1      1 = wrap to step 0 after last; sampled on start
//   start      in   1      one-cycle pulse: begin playback at step 0
//   stop       in   1      one-cycle pulse: abort playback
//   red        out  1      registered LED drive
//   green      out  1      registered LED drive
//   blue       out  1      registered LED drive
//   busy       out  1      1 while in RUN
//   done       out  1      one-cycle pulse at normal end of a non-looped sequence
// BEHAVIOUR
//   - Reset: state=IDLE; red/green/blue/busy/done=0; cfg_ready=1; all table entries
//     cleared to colour 000, dur 0; step index, prescaler and step timer = 0.
//   - Reset mid-RUN: same values in the next cycle; the table is cleared.
//   - Table write: occurs when cfg_valid&&cfg_ready. The entry is visible from the next cycle.
//     When cfg_ready=0, cfg_valid is ignored and the table is unchanged.
//   - States: IDLE, RUN, FIN.
//     - IDLE -> RUN on start&&!stop. The entry cycle latches cfg_last and loop_en,
//       sets idx=0, clears the prescaler and loads the timer with max(dur[0],1).
//     - RUN: the prescaler counts 0..TICK_DIV-1 and emits a tick at TICK_DIV-1.
//       On a tick with timer>1, timer decrements. On a tick with timer==1, the sequencer advances.
//     - Advance when idx<last: idx+1 and reload the timer.
//     - Advance when idx==last with loop: idx=0 and reload the timer.
//     - Advance when idx==last without loop: go to FIN.
//     - FIN: lasts exactly one cycle with done=1, busy=0 and LED=000. It then goes to IDLE.
//     - RUN -> IDLE on stop: LED=000 and busy=0 next cycle. No done pulse.
//       Stop has priority over a same-cycle tick or advance.
//     - start in RUN or FIN is ignored. start&&stop in IDLE stays in IDLE.
//   - Latency: start at cycle N gives busy=1 and LED=colour[0] at N+1.
//     Step k is displayed for max(dur[k],1)*TICK_DIV cycles.
//     A colour change is visible one cycle after its advancing tick.
//   - cfg_last >= NUM_STEPS cannot occur, since IW bits cover the range.
//     A non-looped sequence with cfg_last=0 plays step 0 only.
//   - Widths: the prescaler is $clog2(TICK_DIV) bits and the timer is DUR_W bits.
//     Neither wraps, since both reload before overflow.
// CONFIGURATION
//   PWM_DIM_EN defined:
//     - Adds input brightness[3:0] and a free-running 4-bit counter pwm_cnt (reset 0).
//     - Each colour bit is ANDed with (pwm_cnt < brightness), giving duty brightness/16.
//     - brightness=0 gives LED off. The counter also runs in IDLE, but the LED stays 000 there.
//   PWM_DIM_EN undefined:
//     - No brightness port, no counter; colours are driven at full on.
// TESTING  (bench uses TICK_DIV=4, NUM_STEPS=8, DUR_W=10)
//   1. rst=1 for 2 cycles -> red/green/blue=000, busy=0, done=0, cfg_ready=1.
//   2. Load {100,d2},{010,d1},{001,d3}; cfg_last=2, loop_en=0; start -> LED 100 for 8 cycles,
//      then 010 for 4, then 001 for 12. Then done=1 for one cycle with LED 000, then busy=0.
//   3. Same table with loop_en=1 -> after 001 for 12 cycles, LED returns to 100; done stays 0;
//      the sequence repeats every 24 cycles.
//   4. stop during step 1 -> next cycle LED=000, busy=0, done=0.
//      start&&stop in IDLE -> busy stays 0.
//   5. While busy, cfg_valid with idx0={111,d5} -> cfg_ready=0. After stop and a re-run,
//      step 0 is still 100 for 8 cycles.
//   6. PWM_DIM_EN, brightness=4, step 0=100 -> red high for 4 of every 16 cycles.
//      brightness=0 -> red stays 0.

Source files
------------

// File: rtl/rgb_sequence_ctrl.sv
// Table-driven RGB LED sequencer: loads {colour, duration} steps, then plays them once or looped.
// Optional PWM_DIM_EN adds a brightness input that dims the LED with a 4-bit duty counter.
module rgb_sequence_ctrl #(
  parameter int NUM_STEPS = 8,
  parameter int TICK_DIV  = 12000,
  parameter int DUR_W     = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [$clog2(NUM_STEPS)-1:0] cfg_idx,
  input  logic [2:0]                   cfg_color,
  input  logic [DUR_W-1:0]             cfg_dur,
  input  logic [$clog2(NUM_STEPS)-1:0] cfg_last,
  input  logic                         loop_en,
  input  logic                         start,
  input  logic                         stop,
`ifdef PWM_DIM_EN
  input  logic [3:0]                   brightness,
`endif
  output logic                         red,
  output logic                         green,
  output logic                         blue,
  output logic                         busy,
  output logic                         done
);

  localparam int IW = $clog2(NUM_STEPS);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [PW-1:0]    PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);

  logic [1:0]       r_state, w_state_nx;
  logic [IW-1:0]    r_idx, w_idx_nx, w_idx_inc;
  logic [IW-1:0]    r_last, w_last_nx;
  logic             r_loop, w_loop_nx;
  logic [PW-1:0]    r_pre, w_pre_nx;
  logic [DUR_W-1:0] r_timer, w_timer_nx;
  logic [2:0]       r_tbl_color [NUM_STEPS];
  logic [DUR_W-1:0] r_tbl_dur   [NUM_STEPS];
  logic [2:0]       r_led, w_color_nx;
  logic             w_tick, w_pwm_on, w_cfg_wr;

  function automatic logic [DUR_W-1:0] f_dur(input logic [DUR_W-1:0] d);
    return (d == '0) ? DUR_ONE : d;
  endfunction

  assign w_tick    = (r_pre == PRE_MAX);
  assign w_idx_inc = (r_idx == r_last) ? '0 : r_idx + IW'(1);
  assign w_cfg_wr  = cfg_valid && (r_state == S_IDLE);

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_last_nx  = r_last;
    w_loop_nx  = r_loop;
    w_pre_nx   = r_pre;
    w_timer_nx = r_timer;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_state_nx = S_RUN;
          w_last_nx  = cfg_last;
          w_loop_nx  = loop_en;
          w_idx_nx   = '0;
          w_pre_nx   = '0;
          w_timer_nx = f_dur(r_tbl_dur[0]);
        end
      end
      S_RUN: begin
        // stop wins over any same-cycle tick or advance
        if (stop) begin
          w_state_nx = S_IDLE;
        end else begin
          w_pre_nx = w_tick ? '0 : r_pre + PW'(1);
          if (w_tick) begin
            if (r_timer > DUR_ONE) begin
              w_timer_nx = r_timer - DUR_ONE;
            end else if ((r_idx != r_last) || r_loop) begin
              w_idx_nx   = w_idx_inc;
              w_timer_nx = f_dur(r_tbl_dur[w_idx_inc]);
            end else begin
              w_state_nx = S_FIN;
            end
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    // the table is frozen outside IDLE, so the next step's colour can be looked up directly
    w_color_nx = (w_state_nx == S_RUN) ? r_tbl_color[w_idx_nx] : '0;
  end

`ifdef PWM_DIM_EN
  logic [3:0] r_pwm;

  always_ff @(posedge clk) begin
    if (rst) r_pwm <= '0;
    else     r_pwm <= r_pwm + 4'd1;
  end

  assign w_pwm_on = (r_pwm < brightness);
`else
  assign w_pwm_on = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_last      <= '0;
      r_loop      <= 1'b0;
      r_pre       <= '0;
      r_timer     <= '0;
      r_led       <= '0;
      r_tbl_color <= '{default: '0};
      r_tbl_dur   <= '{default: '0};
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_last  <= w_last_nx;
      r_loop  <= w_loop_nx;
      r_pre   <= w_pre_nx;
      r_timer <= w_timer_nx;
      r_led   <= w_color_nx & {3{w_pwm_on}};
      if (w_cfg_wr) begin
        r_tbl_color[cfg_idx] <= cfg_color;
        r_tbl_dur[cfg_idx]   <= cfg_dur;
      end
    end
  end

  assign red       = r_led[2];
  assign green     = r_led[1];
  assign blue      = r_led[0];
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_FIN);
  assign cfg_ready = (r_state == S_IDLE);

endmodule

// File: tb/tb_rgb_sequence_ctrl.sv
// Bench for rgb_sequence_ctrl: expected LED/busy/done streams are generated from the loaded table.
module tb_rgb_sequence_ctrl;
  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst, cfg_valid, cfg_ready, loop_en, start, stop;
  logic [2:0] cfg_idx, cfg_color, cfg_last;
  logic [9:0] cfg_dur;
  logic       red, green, blue, busy, done;
`ifdef PWM_DIM_EN
  logic [3:0] brightness;
`endif

  rgb_sequence_ctrl #(.NUM_STEPS(8), .TICK_DIV(TD), .DUR_W(10)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_idx(cfg_idx), .cfg_color(cfg_color), .cfg_dur(cfg_dur),
    .cfg_last(cfg_last), .loop_en(loop_en), .start(start), .stop(stop),
`ifdef PWM_DIM_EN
    .brightness(brightness),
`endif
    .red(red), .green(green), .blue(blue), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_color [8];
  int m_dur   [8];
  int q_exp [$];
  int m_full;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] obs();
    return {done, busy, red, green, blue};
  endfunction

  // Expected {done,busy,rgb} per cycle after the start edge; m_full = length of one pass.
  function automatic void fill_exp(input int last, input int loop, input int ncyc);
    int k;
    int d;
    bit ended;
    k = 0;
    ended = 0;
    m_full = 0;
    q_exp.delete();
    while (q_exp.size() < ncyc || m_full == 0) begin
      if (ended) begin
        q_exp.push_back(0);
      end else begin
        d = (m_dur[k] == 0) ? 1 : m_dur[k];
        for (int j = 0; j < d * TD; j++) q_exp.push_back(8 | m_color[k]);
        if (k == last) begin
          if (m_full == 0) m_full = q_exp.size();
          if (loop != 0) k = 0;
          else begin
            q_exp.push_back(16);
            ended = 1;
          end
        end else begin
          k++;
        end
      end
    end
  endfunction

  task automatic write_entry(input int idx, input int col, input int dur);
    cfg_valid = 1'b1;
    cfg_idx   = 3'(idx);
    cfg_color = 3'(col);
    cfg_dur   = 10'(dur);
    step();
    cfg_valid = 1'b0;
    m_color[idx] = col;
    m_dur[idx]   = dur;
  endtask

  task automatic do_start(input int last, input int loop);
    cfg_last = 3'(last);
    loop_en  = (loop != 0);
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic load_basic();
    write_entry(0, 3'b100, 2);
    write_entry(1, 3'b010, 1);
    write_entry(2, 3'b001, 3);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({red, green, blue} !== 3'b000) begin errors++; $display("FAIL reset_led got %b exp 000", {red, green, blue}); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cfg_ready); end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin m_color[i] = 0; m_dur[i] = 0; end
  endtask

  task automatic test_oneshot();
    int n;
    load_basic();
    fill_exp(2, 0, 1);
    n = m_full + 2;
    fill_exp(2, 0, n);
    do_start(2, 0);
    for (int i = 0; i < n; i++) begin
      if (i > 0) step();
      checks++;
      if (obs() !== 5'(q_exp[i])) begin
        errors++;
        $display("FAIL oneshot cyc %0d got %b exp %b", i, obs(), 5'(q_exp[i]));
      end
    end
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL oneshot_ready got %b exp 1", cfg_ready); end
  endtask

  task automatic test_loop();
    fill_exp(2, 1, 60);
    do_start(2, 1);
    for (int i = 0; i < 60; i++) begin
      if (i > 0) step();
      checks++;
      if (obs() !== 5'(q_exp[i])) begin
        errors++;
        $display("FAIL loop cyc %0d got %b exp %b", i, obs(), 5'(q_exp[i]));
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (obs() !== 5'b0) begin errors++; $display("FAIL loop_stop got %b exp 00000", obs()); end
  endtask

  task automatic test_stop();
    fill_exp(2, 1, 9);
    do_start(2, 1);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      checks++;
      if (obs() !== 5'(q_exp[i])) begin
        errors++;
        $display("FAIL stop_pre cyc %0d got %b exp %b", i, obs(), 5'(q_exp[i]));
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (obs() !== 5'b0) begin errors++; $display("FAIL stop_step1 got %b exp 00000", obs()); end
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_idle busy got %b exp 0", busy); end
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL start_stop_idle ready got %b exp 1", cfg_ready); end
  endtask

  task automatic test_cfg_blocked();
    int n;
    fill_exp(2, 1, 4);
    do_start(2, 1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      checks++;
      if (obs() !== 5'(q_exp[i])) begin
        errors++;
        $display("FAIL blocked_pre cyc %0d got %b exp %b", i, obs(), 5'(q_exp[i]));
      end
    end
    cfg_valid = 1'b1;
    cfg_idx   = 3'd0;
    cfg_color = 3'b111;
    cfg_dur   = 10'd5;
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL blocked_ready got %b exp 0", cfg_ready); end
    step();
    cfg_valid = 1'b0;
    checks++;
    if (obs() !== 5'(q_exp[3])) begin errors++; $display("FAIL blocked_run got %b exp %b", obs(), 5'(q_exp[3])); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    fill_exp(2, 0, 1);
    n = m_full + 2;
    fill_exp(2, 0, n);
    do_start(2, 0);
    for (int i = 0; i < n; i++) begin
      if (i > 0) step();
      checks++;
      if (obs() !== 5'(q_exp[i])) begin
        errors++;
        $display("FAIL blocked_rerun cyc %0d got %b exp %b", i, obs(), 5'(q_exp[i]));
      end
    end
  endtask

  task automatic test_random();
    int last, loop, n, early;
    for (int it = 0; it < 25; it++) begin
      for (int w = 0; w < int'($urandom_range(0, 4)); w++)
        write_entry(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      last  = int'($urandom_range(0, 7));
      loop  = int'($urandom_range(0, 1));
      early = (loop == 0) && ($urandom_range(0, 2) == 0);
      fill_exp(last, loop, 1);
      if (loop != 0)  n = int'($urandom_range(1, 2 * m_full));
      else if (early) n = int'($urandom_range(1, m_full));
      else            n = m_full + 2;
      fill_exp(last, loop, n);
      do_start(last, loop);
      for (int i = 0; i < n; i++) begin
        if (i > 0) step();
        checks++;
        if (obs() !== 5'(q_exp[i])) begin
          errors++;
          $display("FAIL random it %0d cyc %0d got %b exp %b", it, i, obs(), 5'(q_exp[i]));
        end
      end
      if (loop != 0 || early) begin
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (obs() !== 5'b0) begin errors++; $display("FAIL random_stop it %0d got %b exp 00000", it, obs()); end
      end
    end
  endtask

  task automatic test_reset_midrun();
    int n;
    load_basic();
    do_start(2, 1);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({obs(), cfg_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_midrun got %b exp 000001", {obs(), cfg_ready});
    end
    for (int i = 0; i < 8; i++) begin m_color[i] = 0; m_dur[i] = 0; end
    fill_exp(7, 0, 1);
    n = m_full + 2;
    fill_exp(7, 0, n);
    do_start(7, 0);
    for (int i = 0; i < n; i++) begin
      if (i > 0) step();
      checks++;
      if (obs() !== 5'(q_exp[i])) begin
        errors++;
        $display("FAIL cleared_table cyc %0d got %b exp %b", i, obs(), 5'(q_exp[i]));
      end
    end
  endtask

`ifdef PWM_DIM_EN
  task automatic test_pwm();
    int cnt;
    write_entry(0, 3'b100, 200);
    brightness = 4'd4;
    do_start(0, 1);
    cnt = 0;
    for (int i = 0; i < 64; i++) begin step(); cnt += int'(red); end
    checks++;
    if (cnt !== 16) begin errors++; $display("FAIL pwm_b4 red high %0d of 64 exp 16", cnt); end
    brightness = 4'd0;
    cnt = 0;
    for (int i = 0; i < 64; i++) begin step(); cnt += int'(red); end
    checks++;
    if (cnt !== 0) begin errors++; $display("FAIL pwm_b0 red high %0d of 64 exp 0", cnt); end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_idx = '0; cfg_color = '0; cfg_dur = '0;
    cfg_last = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
`ifdef PWM_DIM_EN
    brightness = 4'd0;
`endif
    test_reset();
`ifdef PWM_DIM_EN
    test_pwm();
`else
    test_oneshot();
    test_loop();
    test_stop();
    test_cfg_blocked();
    test_random();
    test_reset_midrun();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
